// File: rtl/dcache_uncached_issue.sv
// Uncached load/store issue front-end for dcache_pass; loads block, stores post.
// Define DCACHE_UNCACHED_STRICT_EN to make every store block until its ack.
package dcache_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] paddr;
    logic [3:0]  be;
    logic [31:0] wrdata;
  } dcache_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] rddata;
  } dcache_resp;

endpackage

module dcache_uncached_issue
  import dcache_pkg::*;
#(
  parameter int MAX_PENDING = 8,
  parameter int CNT_WIDTH   = $clog2(MAX_PENDING + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_paddr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wrdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rddata,
  output dcache_req   pass_req,
  output logic        pass_push,
  input  logic        pass_full,
  input  dcache_resp  pass_resp
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT =
    CNT_WIDTH'(MAX_PENDING);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ISSUE_IDLE,
    ISSUE_WAIT_LOAD
`ifdef DCACHE_UNCACHED_STRICT_EN
    , ISSUE_WAIT_STORE
`endif
  } issue_state_e;

  issue_state_e         state;
  logic [CNT_WIDTH-1:0] pending;
  logic [CNT_WIDTH-1:0] skip;
  logic [CNT_WIDTH-1:0] skip_init;
  logic                 resp_dec;

  always_comb begin
    req_ready = (state == ISSUE_IDLE)
              && !pass_full
              && (pending < MAX_CNT);
  end

  assign pass_push = req_valid & req_ready;

  always_comb begin
    pass_req        = '0;
    pass_req.read   = req_read;
    pass_req.write  = req_write;
    pass_req.paddr  = req_paddr;
    pass_req.be     = req_be;
    pass_req.wrdata = req_wrdata;
  end

  // A stray response with nothing in flight is dropped, never wrapped.
  assign resp_dec  = pass_resp.valid && (pending != '0);
  assign skip_init = resp_dec ? pending - ONE : pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (pass_resp.valid)
        assert (pending != '0);
      if (pass_push && !resp_dec)
        pending <= pending + ONE;
      else if (!pass_push && resp_dec)
        pending <= pending - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ISSUE_IDLE;
      skip        <= '0;
      resp_valid  <= 1'b0;
      resp_rddata <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        ISSUE_IDLE: begin
          if (pass_push && req_read) begin
            skip  <= skip_init;
            state <= ISSUE_WAIT_LOAD;
          end
`ifdef DCACHE_UNCACHED_STRICT_EN
          else if (pass_push) begin
            skip  <= skip_init;
            state <= ISSUE_WAIT_STORE;
          end
`endif
        end
        ISSUE_WAIT_LOAD: begin
          // Hold one extra cycle so ready stays low while resp_valid is up.
          if (resp_valid) begin
            state <= ISSUE_IDLE;
          end else if (pass_resp.valid) begin
            if (skip == '0) begin
              resp_valid  <= 1'b1;
              resp_rddata <= pass_resp.rddata;
            end else begin
              skip <= skip - ONE;
            end
          end
        end
`ifdef DCACHE_UNCACHED_STRICT_EN
        ISSUE_WAIT_STORE: begin
          if (pass_resp.valid) begin
            if (skip == '0)
              state <= ISSUE_IDLE;
            else
              skip <= skip - ONE;
          end
        end
`endif
        default: state <= ISSUE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_uncached_issue.sv
// Self-checking bench for dcache_uncached_issue: directed scenarios
// plus a randomized run against an in-flight queue model.
module tb_dcache_uncached_issue;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_paddr;
  logic [3:0]  req_be;
  logic [31:0] req_wrdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rddata;
  dcache_req   pass_req;
  logic        pass_push;
  logic        pass_full;
  dcache_resp  pass_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_uncached_issue dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_paddr   (req_paddr),
    .req_be      (req_be),
    .req_wrdata  (req_wrdata),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_rddata (resp_rddata),
    .pass_req    (pass_req),
    .pass_push   (pass_push),
    .pass_full   (pass_full),
    .pass_resp   (pass_resp)
  );

  task automatic drive_idle();
    req_valid        = 1'b0;
    req_read         = 1'b0;
    req_write        = 1'b0;
    req_paddr        = '0;
    req_be           = '0;
    req_wrdata       = '0;
    pass_full        = 1'b0;
    pass_resp.valid  = 1'b0;
    pass_resp.rddata = '0;
  endtask

  task automatic drive_req(input bit rd, input logic [31:0] a,
                           input logic [31:0] d);
    req_valid  = 1'b1;
    req_read   = rd;
    req_write  = !rd;
    req_paddr  = a;
    req_be     = 4'hF;
    req_wrdata = d;
  endtask

  task automatic ack(input logic [31:0] d);
    pass_resp.valid  = 1'b1;
    pass_resp.rddata = d;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid);
    end
    checks++;
    if (resp_rddata !== 32'h0) begin
      errors++; $display("FAIL reset_rddata got %h exp 0", resp_rddata);
    end
    checks++;
    if (pass_push !== 1'b0) begin
      errors++; $display("FAIL reset_push got %b exp 0", pass_push);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_load();
    drive_req(1'b1, 32'h1FC0_0000, 32'h0);
    #1;
    checks++;
    if (pass_push !== 1'b1 || pass_req.paddr !== 32'h1FC0_0000
        || pass_req.read !== 1'b1) begin
      errors++;
      $display("FAIL load_push push %b addr %h rd %b exp 1 1fc00000 1",
               pass_push, pass_req.paddr, pass_req.read);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      drive_idle();
      if (i == 5) ack(32'hDEAD_BEEF);
      #1;
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_wait%0d ready %b rv %b exp 0 0",
                 i, req_ready, resp_valid);
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rddata !== 32'hDEAD_BEEF
        || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_resp rv %b data %h ready %b exp 1 deadbeef 0",
               resp_valid, resp_rddata, req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_after rv %b ready %b exp 0 1",
               resp_valid, req_ready);
    end
  endtask

  task automatic test_posted_stores();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_idle();
      drive_req(i == 3, 32'h1000_0000 + 32'(i * 4), 32'(i));
      #1;
      checks++;
      if (pass_push !== 1'b1) begin
        errors++; $display("FAIL posted_push%0d got %b exp 1", i, pass_push);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_idle();
      if (i < 3) ack(32'h0000_00A0 + 32'(i));
      if (i == 3) ack(32'h1234_5678);
      #1;
      if (i < 4) begin
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL posted_skip%0d rv %b ready %b exp 0 0",
                   i, resp_valid, req_ready);
        end
      end else begin
        checks++;
        if (resp_valid !== 1'b1 || resp_rddata !== 32'h1234_5678) begin
          errors++;
          $display("FAIL posted_data rv %b data %h exp 1 12345678",
                   resp_valid, resp_rddata);
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_same_cycle_ack();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idle();
      drive_req(i == 2, 32'h2000_0000, 32'h0);
      if (i == 2) ack(32'h1111_1111);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idle();
      if (i == 0) ack(32'h2222_2222);
      if (i == 1) ack(32'hAABB_CCDD);
      #1;
      if (i < 2) begin
        checks++;
        if (resp_valid !== 1'b0) begin
          errors++; $display("FAIL samecyc_early%0d rv %b exp 0", i, resp_valid);
        end
      end else begin
        checks++;
        if (resp_valid !== 1'b1 || resp_rddata !== 32'hAABB_CCDD) begin
          errors++;
          $display("FAIL samecyc_data rv %b data %h exp 1 aabbccdd",
                   resp_valid, resp_rddata);
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_idle();
      drive_req(1'b0, 32'h3000_0000, 32'h55);
      pass_full = (i < 4);
      #1;
      checks++;
      if (i < 4 && (req_ready !== 1'b0 || pass_push !== 1'b0)) begin
        errors++;
        $display("FAIL full_stall%0d ready %b push %b exp 0 0",
                 i, req_ready, pass_push);
      end else if (i == 4 && pass_push !== 1'b1) begin
        errors++; $display("FAIL full_release push %b exp 1", pass_push);
      end
    end
    @(negedge clk);
    drive_idle();
    ack(32'h0);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_max_pending();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_idle();
      drive_req(1'b0, 32'h4000_0000 + 32'(i), 32'(i));
      if (i == 9) ack(32'h0);
      #1;
      checks++;
      if (i < 8 || i == 10) begin
        if (pass_push !== 1'b1) begin
          errors++; $display("FAIL maxpend_push%0d got %b exp 1", i, pass_push);
        end
      end else if (req_ready !== 1'b0 || pass_push !== 1'b0) begin
        errors++;
        $display("FAIL maxpend_block%0d ready %b push %b exp 0 0",
                 i, req_ready, pass_push);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_idle();
      ack(32'h0);
    end
    @(negedge clk);
    drive_idle();
  endtask

`ifdef DCACHE_UNCACHED_STRICT_EN
  task automatic test_strict_store();
    @(negedge clk);
    drive_idle();
    drive_req(1'b0, 32'h1FAF_0000, 32'hCAFE_F00D);
    #1;
    checks++;
    if (pass_push !== 1'b1) begin
      errors++; $display("FAIL strict_push got %b exp 1", pass_push);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive_idle();
      if (i == 3) ack(32'h0);
      #1;
      checks++;
      if (req_ready !== (i == 4) || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL strict_wait%0d ready %b rv %b exp %0d 0",
                 i, req_ready, resp_valid, i == 4);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    @(negedge clk);
    drive_idle();
    drive_req(1'b1, 32'h5000_0000, 32'h0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0
        || resp_rddata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_state ready %b rv %b data %h exp 1 0 0",
               req_ready, resp_valid, resp_rddata);
    end
    @(negedge clk);
    drive_req(1'b1, 32'h5000_0004, 32'h0);
    @(negedge clk);
    drive_idle();
    ack(32'h5A5A_5A5A);
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rddata !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL midrst_pending rv %b data %h exp 1 5a5a5a5a",
               resp_valid, resp_rddata);
    end
    @(negedge clk);
  endtask

  // Model: queue of in-flight request kinds (0 posted, 1 load, 2 blocking store).
  task automatic test_random();
    int          inflight[$];
    bit          blocked = 0;
    int          rel = 0;
    bit          exp_rv = 0;
    logic [31:0] exp_rd = '0;
    bit          strict = 0;
    bit          do_resp;
    bit          exp_ready;
    bit          nxt_rv;
    logic [31:0] nxt_rd;
    int          kind;
`ifdef DCACHE_UNCACHED_STRICT_EN
    strict = 1;
`endif
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rel > 0) begin
        rel--;
        if (rel == 0) blocked = 0;
      end
      drive_idle();
      if ($urandom_range(0, 2) != 0)
        drive_req($urandom_range(0, 1) == 1, $urandom, $urandom);
      req_be    = 4'($urandom);
      pass_full = ($urandom_range(0, 5) == 0);
      do_resp   = (inflight.size() > 0) && ($urandom_range(0, 2) == 0);
      if (do_resp) ack($urandom);
      #1;
      checks++;
      if (resp_valid !== exp_rv || (exp_rv && resp_rddata !== exp_rd)) begin
        errors++;
        $display("FAIL rnd_resp cyc %0d rv %b data %h exp %b %h",
                 cyc, resp_valid, resp_rddata, exp_rv, exp_rd);
      end
      exp_ready = !blocked && !pass_full && (inflight.size() < 8);
      checks++;
      if (req_ready !== exp_ready
          || pass_push !== (req_valid && exp_ready)) begin
        errors++;
        $display("FAIL rnd_ready cyc %0d ready %b push %b exp %b %b",
                 cyc, req_ready, pass_push, exp_ready,
                 req_valid && exp_ready);
      end
      if (pass_push) begin
        checks++;
        if (pass_req.paddr !== req_paddr || pass_req.be !== req_be
            || pass_req.wrdata !== req_wrdata
            || pass_req.read !== req_read
            || pass_req.write !== req_write) begin
          errors++;
          $display("FAIL rnd_passreq cyc %0d addr %h exp %h",
                   cyc, pass_req.paddr, req_paddr);
        end
      end
      nxt_rv = 0;
      nxt_rd = '0;
      if (do_resp) begin
        kind = inflight.pop_front();
        if (kind == 1) begin
          nxt_rv = 1;
          nxt_rd = pass_resp.rddata;
          rel    = 2;
        end else if (kind == 2) begin
          rel = 1;
        end
      end
      if (req_valid && exp_ready) begin
        kind = req_read ? 1 : (strict ? 2 : 0);
        inflight.push_back(kind);
        if (kind != 0) blocked = 1;
      end
      exp_rv = nxt_rv;
      exp_rd = nxt_rd;
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_load();
`ifdef DCACHE_UNCACHED_STRICT_EN
    test_strict_store();
`else
    test_posted_stores();
    test_same_cycle_ack();
    test_max_pending();
`endif
    test_full_stall();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
